// File: rtl/qm_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package qm_muldiv_pkg;

  // Operation codes as issued by the control unit.
  typedef enum logic [1:0] {
    MdMult  = 2'd0,
    MdMultu = 2'd1,
    MdDiv   = 2'd2,
    MdDivu  = 2'd3
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } md_state_e;

  // Divide ops have the upper code bit set.
  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  // Signed ops have the lower code bit clear.
  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/qm_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// The accumulator packs {upper, lower} halves:
//   multiply: {partial product high, remaining multiplier bits}
//   divide:   {partial remainder, dividend bits shifting into quotient}
module qm_muldiv_step
  import qm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_IsDiv,
  input  logic [2*WIDTH-1:0] i_Acc,
  input  logic [WIDTH-1:0]   i_Operand,
  output logic [2*WIDTH-1:0] o_Acc
);

  logic [WIDTH:0] w_mul_sum;
  logic [WIDTH:0] w_div_rem;
  logic [WIDTH:0] w_div_trial;

  // Shift-add for multiply, restoring compare/subtract/shift for divide.
  always_comb begin
    w_mul_sum   = {1'b0, i_Acc[2*WIDTH-1:WIDTH]} +
                  (i_Acc[0] ? {1'b0, i_Operand} : {(WIDTH + 1){1'b0}});
    // Remainder shifted left by one with the next dividend bit brought in.
    w_div_rem   = i_Acc[2*WIDTH-1:WIDTH-1];
    w_div_trial = w_div_rem - {1'b0, i_Operand};
    if (i_IsDiv) begin
      // Top bit of the trial difference set means the subtraction borrowed.
      if (!w_div_trial[WIDTH]) begin
        o_Acc = {w_div_trial[WIDTH-1:0], i_Acc[WIDTH-2:0], 1'b1};
      end else begin
        o_Acc = {w_div_rem[WIDTH-1:0], i_Acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry-out of the add becomes the new top bit after the right shift.
      o_Acc = {w_mul_sum, i_Acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/qm_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Latency from accepted start to HI/LO update is WIDTH+1 edges.
module qm_muldiv
  import qm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  input  logic [1:0]       i_Op,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cancel,
  input  logic             i_HiWrite,
  input  logic             i_LoWrite,
  input  logic [WIDTH-1:0] i_WData,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Hi,
  output logic [WIDTH-1:0] o_Lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  md_state_e          r_state;
  md_op_e             r_op;
  logic [CntW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  md_op_e             w_start_op;
  logic               w_start_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand magnitudes for signed ops; unsigned ops pass through.
  always_comb begin
    w_start_op     = md_op_e'(i_Op);
    w_start_signed = op_is_signed(w_start_op);
    w_abs_a        = (w_start_signed && i_A[WIDTH-1]) ? -i_A : i_A;
    w_abs_b        = (w_start_signed && i_B[WIDTH-1]) ? -i_B : i_B;
  end

  qm_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_IsDiv  (op_is_div(r_op)),
    .i_Acc    (r_acc),
    .i_Operand(r_operand),
    .o_Acc    (w_step_acc)
  );

  // Sign correction and divide-by-zero override applied in the FIX state.
  always_comb begin
    w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    w_quot   = r_acc[WIDTH-1:0];
    w_rem    = r_acc[2*WIDTH-1:WIDTH];
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (op_is_div(r_op)) begin
      // Magnitude of the divisor is zero only when the divisor itself is zero.
      if (r_operand == '0) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_lo = (r_sign_a ^ r_sign_b) ? -w_quot : w_quot;
        w_fix_hi = r_sign_a ? -w_rem : w_rem;
      end
    end
  end

  // Sequencer, working registers and HI/LO with registered status outputs.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state   <= StIdle;
      r_op      <= MdMult;
      r_count   <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_a_raw   <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_HiWrite) begin
            r_hi <= i_WData;
          end
          if (i_LoWrite) begin
            r_lo <= i_WData;
          end
          // Cancel takes priority over a simultaneous start.
          if (i_Start && !i_Cancel) begin
            r_op     <= w_start_op;
            r_count  <= '0;
            r_a_raw  <= i_A;
            r_sign_a <= w_start_signed & i_A[WIDTH-1];
            r_sign_b <= w_start_signed & i_B[WIDTH-1];
            if (op_is_div(w_start_op)) begin
              r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
              r_operand <= w_abs_b;
            end else begin
              r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
              r_operand <= w_abs_a;
            end
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (i_Cancel) begin
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_acc   <= w_step_acc;
            r_count <= r_count + CntW'(1);
            if (r_count == CntW'(WIDTH - 1)) begin
              r_state <= StFix;
            end
          end
        end
        StFix: begin
          r_count <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
          if (!i_Cancel) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_Busy = r_busy;
  assign o_Done = r_done;
  assign o_Hi   = r_hi;
  assign o_Lo   = r_lo;

endmodule

// File: tb/tb_qm_muldiv.sv
// Scoreboard bench for qm_muldiv: driver pushes expected HI/LO and done cycle,
// a monitor pops and compares on every o_Done pulse.
module tb_qm_muldiv;

  logic        clk;
  logic        rst_n;
  logic        i_Start;
  logic [1:0]  i_Op;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        i_Cancel;
  logic        i_HiWrite;
  logic        i_LoWrite;
  logic [31:0] i_WData;
  logic        o_Busy;
  logic        o_Done;
  logic [31:0] o_Hi;
  logic [31:0] o_Lo;

  qm_muldiv #(
    .WIDTH(32)
  ) dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .i_Start  (i_Start),
    .i_Op     (i_Op),
    .i_A      (i_A),
    .i_B      (i_B),
    .i_Cancel (i_Cancel),
    .i_HiWrite(i_HiWrite),
    .i_LoWrite(i_LoWrite),
    .i_WData  (i_WData),
    .o_Busy   (o_Busy),
    .o_Done   (o_Done),
    .o_Hi     (o_Hi),
    .o_Lo     (o_Lo)
  );

  typedef struct {
    logic [63:0] hilo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_done   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic, result packed as {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && o_Done) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        chk(1'b0, "unexpected_done", {o_Hi, o_Lo}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk({o_Hi, o_Lo} == e.hilo, "hilo", {o_Hi, o_Lo}, e.hilo);
        chk(cyc == e.cyc, "done_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Must be called at a negedge; returns at the negedge after E33.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input bit mt_with_start);
    exp_t e;
    bit busy_ok;
    logic [31:0] hi_before;
    e.hilo = ref_md(op, a, b);
    e.cyc  = cyc + 34;
    sb_q.push_back(e);
    i_Op = op;
    i_A = a;
    i_B = b;
    i_Start = 1'b1;
    if (mt_with_start) begin
      i_HiWrite = 1'b1;
      i_WData = a ^ 32'h5A5A_0000;
    end
    hi_before = mt_with_start ? (a ^ 32'h5A5A_0000) : m_hi;
    busy_ok = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    i_HiWrite = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (!o_Busy) busy_ok = 1'b0;
      if (i == 0 && mt_with_start) chk(o_Hi == hi_before, "mthi_with_start", o_Hi, hi_before);
      if (poke && i == 4) begin
        i_Start = 1'b1;
        i_Op = 2'($urandom_range(0, 3));
        i_A = ~a;
        i_B = b + 32'd3;
        i_LoWrite = 1'b1;
        i_WData = 32'hDEAD_BEEF;
      end
      if (poke && i == 5) begin
        i_Start = 1'b0;
        i_LoWrite = 1'b0;
        chk(o_Lo == m_lo, "mtlo_while_busy", o_Lo, m_lo);
      end
      @(negedge clk);
    end
    chk(busy_ok, "busy_high_e0_e33", 64'(busy_ok), 64'd1);
    chk(!o_Busy, "busy_low_after_e33", 64'(o_Busy), 64'd0);
    m_hi = e.hilo[63:32];
    m_lo = e.hilo[31:0];
  endtask

  initial begin
    int done_before;
    logic [31:0] a, b;
    logic [1:0] op;
    rst_n = 1'b0;
    i_Start = 1'b0;
    i_Op = 2'd0;
    i_A = '0;
    i_B = '0;
    i_Cancel = 1'b0;
    i_HiWrite = 1'b0;
    i_LoWrite = 1'b0;
    i_WData = '0;
    @(negedge clk);
    @(negedge clk);
    chk({o_Busy, o_Done, o_Hi, o_Lo} == '0, "reset_state", {o_Hi, o_Lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MTLO / MTHI in idle.
    i_LoWrite = 1'b1;
    i_WData = 32'h0000_1234;
    @(negedge clk);
    i_LoWrite = 1'b0;
    chk(o_Lo == 32'h1234, "mtlo_idle", o_Lo, 32'h1234);
    i_HiWrite = 1'b1;
    i_WData = 32'h0BAD_F00D;
    @(negedge clk);
    i_HiWrite = 1'b0;
    chk(o_Hi == 32'h0BAD_F00D, "mthi_idle", o_Hi, 32'h0BAD_F00D);
    m_lo = 32'h1234;
    m_hi = 32'h0BAD_F00D;

    // Directed cases, issued back-to-back.
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    run_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);

    // Cancel at E10 of DIVU 100/7.
    done_before = n_done;
    i_Op = 2'd3;
    i_A = 32'd100;
    i_B = 32'd7;
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (10) @(negedge clk);
    i_Cancel = 1'b1;
    @(negedge clk);
    i_Cancel = 1'b0;
    chk(!o_Busy, "busy_low_after_cancel", 64'(o_Busy), 64'd0);
    run_op(2'd1, 32'd12345, 32'd678, 1'b0, 1'b0);
    chk(n_done == done_before + 1, "cancel_no_done", 64'(n_done), 64'(done_before + 1));

    // Cancel in FIX: lands on E33, so nothing written.
    i_Op = 2'd1;
    i_A = 32'd9;
    i_B = 32'd9;
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (32) @(negedge clk);
    i_Cancel = 1'b1;
    @(negedge clk);
    i_Cancel = 1'b0;
    @(negedge clk);
    chk({o_Hi, o_Lo} == {m_hi, m_lo}, "cancel_in_fix_hilo", {o_Hi, o_Lo}, {m_hi, m_lo});

    // Cancel together with start in idle: nothing starts.
    i_Start = 1'b1;
    i_Cancel = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    i_Cancel = 1'b0;
    chk(!o_Busy, "cancel_beats_start", 64'(o_Busy), 64'd0);

    // Randomized operations with corner-biased operands.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset at E20 of a MULT.
    i_Op = 2'd0;
    i_A = 32'hFFFF_FFFD;
    i_B = 32'd7;
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({o_Busy, o_Done, o_Hi, o_Lo} == '0, "async_reset_mid_op", {o_Hi, o_Lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    chk(!o_Busy, "idle_after_reset", 64'(o_Busy), 64'd0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0);

    repeat (40) @(negedge clk);
    chk(sb_q.size() == 0, "scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
